rgb_conv3x3_engine: RTL and testbench
=====================================

# rgb_conv3x3_engine

Consumes the 3-pixel RGB columns produced by the line-buffer window generator and forms a sliding 3x3x3 window. It computes one signed multiply-accumulate output per window position: 27 taps plus bias, in a fixed-latency pipeline. It also tracks output row and column position, suppresses windows that straddle a row boundary, and flags end of frame. It is the first compute stage of the driver-monitoring CNN front end.

## Interface
Parameters:
- DATA_WIDTH, 8, unsigned pixel width
- WEIGHT_WIDTH, 8, signed weight width
- ACC_WIDTH, 24, signed accumulator/output width; must be >= DATA_WIDTH+WEIGHT_WIDTH+6
- IMAGE_SIZE, 224, padded input row length in pixels

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- col_valid  in  1  column present this cycle
- col_r, col_g, col_b  in  3*DATA_WIDTH  column; [0+:DW]=top row, [DW+:DW]=middle, [2DW+:DW]=bottom (newest)
- wt_we  in  1  weight/bias write strobe
- wt_addr  in  5  0..26 = tap (ch*9 + ky*3 + kx; ch 0=R,1=G,2=B; kx 0=oldest column), 27 = bias
- wt_data  in  ACC_WIDTH  signed; taps use low WEIGHT_WIDTH bits, bias uses all
- conv_out  out  ACC_WIDTH  signed result
- conv_valid  out  1  conv_out valid, one-cycle qualifier per result
- out_row  out  8  output row of conv_out, 0..IMAGE_SIZE-3
- out_col  out  8  output column of conv_out, 0..IMAGE_SIZE-3
- frame_done  out  1  one-cycle pulse with the last result of a frame

## Operation
- Window: three column registers per channel, C0 (oldest), C1, C2. On col_valid, C0<=C1, C1<=C2, C2<=input. Without col_valid, the window holds.
- Column index in_col counts 0..IMAGE_SIZE-1 on each col_valid and wraps to 0. in_row increments on wrap.
- Window is eligible when a column is accepted with in_col >= 2. Eligible windows enter the pipeline tagged with (in_row, in_col-2).
- Stage 1 (products): 27 products. Pixels are zero-extended to signed, times the signed weight.
- Stage 2 (channel sums): per-channel sum of 9 products.
- Stage 3 (output): R+G+B sums plus bias are registered into conv_out. Arithmetic is two's-complement in ACC_WIDTH with no saturation; ACC_WIDTH guarantees no overflow.
- Valid and position tags travel with the data through every stage. The pipeline advances every cycle regardless of col_valid; there is no stall or backpressure.
- Frame end:
  - The result tagged (IMAGE_SIZE-3, IMAGE_SIZE-3) asserts frame_done with conv_valid.
  - in_row and in_col return to 0 on the accepting cycle of the last column of input row IMAGE_SIZE-3.
  - The next col_valid starts a new frame.
- Weights: 27 tap registers plus bias, written on wt_we in one cycle. wt_addr > 27 is ignored.
  - A write is visible to products computed from windows accepted on later edges.
  - Mid-frame writes are legal but give mixed-weight results; the software loads weights before a frame.
- Reset:
  - Clears window, counters, pipeline valids, conv_out, out_row, out_col, conv_valid and frame_done to 0.
  - Clears all weights and bias to 0.
  - Reset mid-frame discards in-flight results; no conv_valid is produced for them.

## Timing
- Latency: an eligible column accepted at edge N gives conv_valid high after edge N+3, i.e. in cycle N+3.
- Throughput: one result per col_valid cycle. Back-to-back col_valid gives back-to-back conv_valid after the first two columns of each row.
- Per row: IMAGE_SIZE-2 results. The first two columns of each row produce no output.
- Per frame: (IMAGE_SIZE-2)^2 results.
- frame_done is coincident with the final conv_valid; it is never asserted alone.
- col_valid and wt_we in the same cycle are both honoured.

## Structure
- Shared package rgb_conv_pkg holds:
  - DATA_WIDTH, WEIGHT_WIDTH, ACC_WIDTH, NUM_TAPS=27, BIAS_ADDR=27
  - the tap-index function ch*9+ky*3+kx
- One sub-module, conv3x3_channel_mac:
  - 9 pixels plus 9 weights in, registered products, then registered 9-way sum.
  - Instantiated once per channel.
- The top handles the window, counters, weight file, the final sum and the tags.

## Test plan
- Identity: only weight 4 (R, center) = 1, bias 0; IMAGE_SIZE=8, R pixel = row*8+col -> conv_out(r,c) = (r+1)*8+(c+1); 36 results; frame_done on result (5,5).
- Full sum: all 27 weights = 1, bias = -10, all pixels 255 -> every conv_out = 27*255-10 = 6875.
- Signed extremes: all weights -128, pixels 255 -> conv_out = -881280 with no wrap at ACC_WIDTH=24.
- Gaps: col_valid toggled 1,0,1,0 with identity weights -> same values as the back-to-back run, each exactly 3 cycles after its accepting edge; no result for in_col 0 or 1.
- Reset mid-frame: assert rst after 20 columns -> no conv_valid in the following 3 cycles, weights read 0, counters restart at (0,0).
- Weight write with col_valid: write tap 13 = 2 in the same cycle as a column -> that window uses the old value, and the next window uses 2.

Source files
------------

// File: rtl/rgb_conv_pkg.sv
// rgb_conv_pkg
// Shared constants and helpers for the RGB 3x3 convolution engine.
//   - Default data, weight and accumulator widths.
//   - Weight-file geometry: 27 taps followed by the bias register.
//   - tap_idx(): maps (channel, kernel row, kernel column) onto a weight address.
package rgb_conv_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int WEIGHT_WIDTH = 8;
  localparam int ACC_WIDTH    = 24;
  localparam int NUM_TAPS     = 27;
  localparam int BIAS_ADDR    = 27;

  // ch: 0=R, 1=G, 2=B; ky: 0=top row; kx: 0=oldest column
  function automatic int tap_idx(input int ch, input int ky, input int kx);
    return ch * 9 + ky * 3 + kx;
  endfunction

endpackage

// File: rtl/conv3x3_channel_mac.sv
// conv3x3_channel_mac
// One colour channel of the 3x3 multiply-accumulate: nine registered
// unsigned-pixel x signed-weight products, then a registered 9-way sum.
// Total latency is two clocks from pix_i/wt_i to sum_o.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   pix_i  in   9 pixels, tap k = ky*3+kx at [k*DATA_WIDTH +: DATA_WIDTH]
//   wt_i   in   9 signed weights, same tap ordering
//   sum_o  out  signed channel sum, ACC_WIDTH bits
module conv3x3_channel_mac
  import rgb_conv_pkg::*;
#(
  parameter int DATA_WIDTH   = rgb_conv_pkg::DATA_WIDTH,
  parameter int WEIGHT_WIDTH = rgb_conv_pkg::WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = rgb_conv_pkg::ACC_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9*DATA_WIDTH-1:0]       pix_i,
  input  logic [9*WEIGHT_WIDTH-1:0]     wt_i,
  output logic signed [ACC_WIDTH-1:0]   sum_o
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

  logic signed [PW-1:0]        prod_d [9];
  logic signed [PW-1:0]        prod_q [9];
  logic signed [ACC_WIDTH-1:0] sum_d;
  logic signed [ACC_WIDTH-1:0] sum_q;

  // The extra zero bit keeps the pixel positive in the signed multiply;
  // the full product always fits in DATA_WIDTH+WEIGHT_WIDTH bits.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = $signed({1'b0, pix_i[k*DATA_WIDTH +: DATA_WIDTH]}) *
                  $signed(wt_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 9; k++) begin
      sum_d = sum_d + ACC_WIDTH'(prod_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      sum_q <= '0;
    end else begin
      for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/rgb_conv3x3_engine.sv
// rgb_conv3x3_engine
// First compute stage of the CNN front end. Builds a sliding 3x3x3 window
// from incoming RGB pixel columns and produces one signed 27-tap MAC plus
// bias per window position, three clocks after the accepting edge.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   col_valid                column present this cycle
//   col_r/col_g/col_b        3-pixel columns, [0+:DW]=top .. [2DW+:DW]=bottom
//   wt_we/wt_addr/wt_data    weight file write (0..26 taps, 27 bias)
//   conv_out/conv_valid      signed result and its one-cycle qualifier
//   out_row/out_col          output position of conv_out
//   frame_done               pulses with the last result of a frame
module rgb_conv3x3_engine
  import rgb_conv_pkg::*;
#(
  parameter int DATA_WIDTH   = rgb_conv_pkg::DATA_WIDTH,
  parameter int WEIGHT_WIDTH = rgb_conv_pkg::WEIGHT_WIDTH,
  parameter int ACC_WIDTH    = rgb_conv_pkg::ACC_WIDTH,
  parameter int IMAGE_SIZE   = 224
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         col_valid,
  input  logic [3*DATA_WIDTH-1:0]      col_r,
  input  logic [3*DATA_WIDTH-1:0]      col_g,
  input  logic [3*DATA_WIDTH-1:0]      col_b,
  input  logic                         wt_we,
  input  logic [4:0]                   wt_addr,
  input  logic [ACC_WIDTH-1:0]         wt_data,
  output logic signed [ACC_WIDTH-1:0]  conv_out,
  output logic                         conv_valid,
  output logic [7:0]                   out_row,
  output logic [7:0]                   out_col,
  output logic                         frame_done
);

  localparam logic [7:0] LAST_COL = 8'(IMAGE_SIZE - 1);
  localparam logic [7:0] LAST_ROW = 8'(IMAGE_SIZE - 3);

  // Window: index 0 = oldest column (kx=0), index 2 = newest.
  logic [2:0][3*DATA_WIDTH-1:0] win_r_q, win_g_q, win_b_q;

  logic [7:0] in_col_q, in_col_d;
  logic [7:0] in_row_q, in_row_d;
  logic       eligible;

  logic signed [WEIGHT_WIDTH-1:0] wt_q [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]    bias_q;

  // Writes land in the weight file one edge late, so a write sharing an
  // edge with a column only affects windows accepted afterwards.
  logic                 wp_we_q;
  logic [4:0]           wp_addr_q;
  logic [ACC_WIDTH-1:0] wp_data_q;

  // Tag pipeline: [0] aligns with the window, [1] with products,
  // [2] with channel sums. Bias follows the products from stage 1.
  logic       tag_v_q   [3];
  logic [7:0] tag_row_q [3];
  logic [7:0] tag_col_q [3];
  logic signed [ACC_WIDTH-1:0] bias_p_q [2];

  logic signed [ACC_WIDTH-1:0] conv_out_q;
  logic       conv_valid_q, frame_done_q;
  logic [7:0] out_row_q, out_col_q;

  logic [9*DATA_WIDTH-1:0]   pix_r, pix_g, pix_b;
  logic [9*WEIGHT_WIDTH-1:0] wv_r, wv_g, wv_b;
  logic signed [ACC_WIDTH-1:0] sum_r, sum_g, sum_b;

  assign eligible = col_valid && (in_col_q >= 8'd2);

  // Row counter wraps at the last row that still yields outputs: that
  // wrap is the frame boundary.
  always_comb begin
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    if (col_valid) begin
      if (in_col_q == LAST_COL) begin
        in_col_d = '0;
        in_row_d = (in_row_q == LAST_ROW) ? 8'd0 : in_row_q + 8'd1;
      end else begin
        in_col_d = in_col_q + 8'd1;
      end
    end
  end

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    wv_r  = '0;
    wv_g  = '0;
    wv_b  = '0;
    for (int ky = 0; ky < 3; ky++) begin
      for (int kx = 0; kx < 3; kx++) begin
        pix_r[(ky*3+kx)*DATA_WIDTH +: DATA_WIDTH] = win_r_q[kx][ky*DATA_WIDTH +: DATA_WIDTH];
        pix_g[(ky*3+kx)*DATA_WIDTH +: DATA_WIDTH] = win_g_q[kx][ky*DATA_WIDTH +: DATA_WIDTH];
        pix_b[(ky*3+kx)*DATA_WIDTH +: DATA_WIDTH] = win_b_q[kx][ky*DATA_WIDTH +: DATA_WIDTH];
        wv_r[(ky*3+kx)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = wt_q[tap_idx(0, ky, kx)];
        wv_g[(ky*3+kx)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = wt_q[tap_idx(1, ky, kx)];
        wv_b[(ky*3+kx)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = wt_q[tap_idx(2, ky, kx)];
      end
    end
  end

  conv3x3_channel_mac #(
    .DATA_WIDTH(DATA_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH), .ACC_WIDTH(ACC_WIDTH)
  ) u_mac_r (.clk(clk), .rst(rst), .pix_i(pix_r), .wt_i(wv_r), .sum_o(sum_r));

  conv3x3_channel_mac #(
    .DATA_WIDTH(DATA_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH), .ACC_WIDTH(ACC_WIDTH)
  ) u_mac_g (.clk(clk), .rst(rst), .pix_i(pix_g), .wt_i(wv_g), .sum_o(sum_g));

  conv3x3_channel_mac #(
    .DATA_WIDTH(DATA_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH), .ACC_WIDTH(ACC_WIDTH)
  ) u_mac_b (.clk(clk), .rst(rst), .pix_i(pix_b), .wt_i(wv_b), .sum_o(sum_b));

  always_ff @(posedge clk) begin
    if (rst) begin
      win_r_q      <= '0;
      win_g_q      <= '0;
      win_b_q      <= '0;
      in_col_q     <= '0;
      in_row_q     <= '0;
      for (int t = 0; t < NUM_TAPS; t++) wt_q[t] <= '0;
      bias_q       <= '0;
      wp_we_q      <= 1'b0;
      wp_addr_q    <= '0;
      wp_data_q    <= '0;
      for (int s = 0; s < 3; s++) begin
        tag_v_q[s]   <= 1'b0;
        tag_row_q[s] <= '0;
        tag_col_q[s] <= '0;
      end
      bias_p_q[0]  <= '0;
      bias_p_q[1]  <= '0;
      conv_out_q   <= '0;
      conv_valid_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (col_valid) begin
        win_r_q <= {col_r, win_r_q[2], win_r_q[1]};
        win_g_q <= {col_g, win_g_q[2], win_g_q[1]};
        win_b_q <= {col_b, win_b_q[2], win_b_q[1]};
      end
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;

      wp_we_q   <= wt_we;
      wp_addr_q <= wt_addr;
      wp_data_q <= wt_data;
      if (wp_we_q) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
          if (wp_addr_q == 5'(t)) wt_q[t] <= wp_data_q[WEIGHT_WIDTH-1:0];
        end
        if (wp_addr_q == 5'(BIAS_ADDR)) bias_q <= wp_data_q;
      end

      tag_v_q[0]   <= eligible;
      tag_row_q[0] <= in_row_q;
      tag_col_q[0] <= in_col_q - 8'd2;
      for (int s = 1; s < 3; s++) begin
        tag_v_q[s]   <= tag_v_q[s-1];
        tag_row_q[s] <= tag_row_q[s-1];
        tag_col_q[s] <= tag_col_q[s-1];
      end
      bias_p_q[0] <= bias_q;
      bias_p_q[1] <= bias_p_q[0];

      conv_out_q   <= sum_r + sum_g + sum_b + bias_p_q[1];
      conv_valid_q <= tag_v_q[2];
      out_row_q    <= tag_row_q[2];
      out_col_q    <= tag_col_q[2];
      frame_done_q <= tag_v_q[2] && (tag_row_q[2] == LAST_ROW) && (tag_col_q[2] == LAST_ROW);
    end
  end

  assign conv_out   = conv_out_q;
  assign conv_valid = conv_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rgb_conv3x3_engine.sv
// tb_rgb_conv3x3_engine
// Self-checking bench for rgb_conv3x3_engine at IMAGE_SIZE=8. Expected
// results are queued when each column is driven and checked (value, tags,
// frame_done and arrival cycle) when conv_valid appears.
module tb_rgb_conv3x3_engine;

  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 24;
  localparam int IS = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 col_valid = 1'b0;
  logic [3*DW-1:0]      col_r = '0, col_g = '0, col_b = '0;
  logic                 wt_we = 1'b0;
  logic [4:0]           wt_addr = '0;
  logic [AW-1:0]        wt_data = '0;
  logic signed [AW-1:0] conv_out;
  logic                 conv_valid;
  logic [7:0]           out_row, out_col;
  logic                 frame_done;

  rgb_conv3x3_engine #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .IMAGE_SIZE(IS)
  ) dut (
    .clk(clk), .rst(rst), .col_valid(col_valid),
    .col_r(col_r), .col_g(col_g), .col_b(col_b),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .conv_out(conv_out), .conv_valid(conv_valid),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                   row;
    int                   col;
    logic signed [AW-1:0] val;
    bit                   last;
    int                   due;
  } exp_t;

  typedef struct {
    int w;
    int b;
    int pix;
    int exp;
  } vec_t;

  exp_t q[$];
  exp_t me;
  vec_t tab[5];

  int checks = 0;
  int errors = 0;

  int mw[28];
  int m_row = 0, m_col = 0;
  int pat_mode = 0, pat_val = 0;

  function automatic int pix(input int ch, input int r, input int c);
    if (pat_mode != 0) return pat_val;
    case (ch)
      0:       return r * IS + c;
      1:       return (r * 3 + c * 5) % 256;
      default: return (r * 7 + c * 11 + 3) % 256;
    endcase
  endfunction

  // One clock of stimulus; expectations use weights written strictly earlier.
  task automatic drive(input bit v, input bit we, input int a, input int d,
                       input bit use_tab, input int texp);
    exp_t e;
    int   acc;
    col_valid = v;
    wt_we     = we;
    wt_addr   = 5'(a);
    wt_data   = AW'(d);
    if (v) begin
      for (int ky = 0; ky < 3; ky++) begin
        col_r[ky*DW +: DW] = DW'(pix(0, m_row + ky, m_col));
        col_g[ky*DW +: DW] = DW'(pix(1, m_row + ky, m_col));
        col_b[ky*DW +: DW] = DW'(pix(2, m_row + ky, m_col));
      end
      if (m_col >= 2) begin
        acc = mw[27];
        for (int ch = 0; ch < 3; ch++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              acc += mw[ch*9 + ky*3 + kx] * pix(ch, m_row + ky, m_col - 2 + kx);
        e.row  = m_row;
        e.col  = m_col - 2;
        e.val  = use_tab ? AW'(texp) : AW'(acc);
        e.last = (m_row == IS - 3) && (m_col - 2 == IS - 3);
        e.due  = cyc + 4;
        q.push_back(e);
      end
      if (m_col == IS - 1) begin
        m_col = 0;
        m_row = (m_row == IS - 3) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    if (we) begin
      if (a < 27)       mw[a]  = int'($signed(8'(d)));
      else if (a == 27) mw[27] = int'($signed(24'(d)));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_uniform(input int w, input int b);
    for (int t = 0; t < 27; t++) drive(0, 1, t, w, 0, 0);
    drive(0, 1, 27, b, 0, 0);
  endtask

  task automatic load_identity();
    for (int t = 0; t < 27; t++) drive(0, 1, t, (t == 4) ? 1 : 0, 0, 0);
    drive(0, 1, 27, 0, 0, 0);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d results still outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic run_frame(input bit gaps, input bit use_tab, input int texp, input string name);
    for (int n = 0; n < (IS - 2) * IS; n++) begin
      drive(1, 0, 0, 0, use_tab, texp);
      if (gaps) idle(1);
    end
    idle(6);
    check_drained(name);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_result: no conv_valid for (%0d,%0d) due cycle %0d, now %0d",
               q[0].row, q[0].col, q[0].due, cyc);
      void'(q.pop_front());
    end
    if (conv_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: conv_out=%0d row=%0d col=%0d at cycle %0d, required no result",
                 conv_out, out_row, out_col, cyc);
      end else begin
        me = q.pop_front();
        if (conv_out !== me.val || out_row !== 8'(me.row) || out_col !== 8'(me.col) ||
            frame_done !== me.last || cyc != me.due) begin
          errors++;
          $display("FAIL result: got val=%0d row=%0d col=%0d fd=%0b cyc=%0d, required val=%0d row=%0d col=%0d fd=%0b cyc=%0d",
                   conv_out, out_row, out_col, frame_done, cyc,
                   me.val, me.row, me.col, me.last, me.due);
        end
      end
    end else if (frame_done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL frame_done_alone: frame_done=1 with conv_valid=0 at cycle %0d, required 0", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{w:    1, b: -10, pix: 255, exp:    6875};
    tab[1] = '{w: -128, b:   0, pix: 255, exp: -881280};
    tab[2] = '{w:    2, b:   0, pix:   1, exp:      54};
    tab[3] = '{w:   -1, b: 100, pix:  10, exp:    -170};
    tab[4] = '{w:    0, b:  -5, pix:  77, exp:      -5};
    for (int t = 0; t < 28; t++) mw[t] = 0;

    repeat (3) @(posedge clk);
    #1;
    checks++; if (conv_out !== '0)    begin errors++; $display("FAIL reset_conv_out: got %0d, required 0", conv_out); end
    checks++; if (conv_valid !== 1'b0) begin errors++; $display("FAIL reset_conv_valid: got %0b, required 0", conv_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b, required 0", frame_done); end
    checks++; if (out_row !== 8'd0)    begin errors++; $display("FAIL reset_out_row: got %0d, required 0", out_row); end
    checks++; if (out_col !== 8'd0)    begin errors++; $display("FAIL reset_out_col: got %0d, required 0", out_col); end
    rst = 1'b0;
    idle(2);

    // Uniform images against tabulated results.
    pat_mode = 1;
    for (int i = 0; i < 5; i++) begin
      pat_val = tab[i].pix;
      load_uniform(tab[i].w, tab[i].b);
      run_frame(0, 1, tab[i].exp, "uniform_frame");
    end

    // Identity on R center tap, back-to-back then with gaps.
    pat_mode = 0;
    load_identity();
    run_frame(0, 0, 0, "identity_b2b");
    run_frame(1, 0, 0, "identity_gaps");

    // Out-of-range address is ignored; tap 13 written alongside a column.
    drive(0, 1, 30, 99, 0, 0);
    drive(0, 1, 31, -7, 0, 0);
    for (int n = 0; n < (IS - 2) * IS; n++) begin
      if (n == 20) drive(1, 1, 13, 2, 0, 0);
      else         drive(1, 0, 0, 0, 0, 0);
    end
    idle(6);
    check_drained("weight_write_with_col");

    // Reset mid-frame.
    load_identity();
    for (int n = 0; n < 20; n++) drive(1, 0, 0, 0, 0, 0);
    col_valid = 1'b0;
    wt_we     = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    for (int t = 0; t < 28; t++) mw[t] = 0;
    m_row = 0;
    m_col = 0;
    rst   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (conv_valid !== 1'b0) begin
        errors++;
        $display("FAIL quiet_after_reset: conv_valid=%0b in cycle %0d after reset, required 0", conv_valid, i);
      end
    end
    @(posedge clk);
    #1;
    run_frame(0, 0, 0, "frame_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
